// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and baud divisor helper.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_e;

   // Integer clocks per bit; the remainder is dropped, so the line runs slightly fast.
   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Read side of the TX byte FIFO as seen by the UART drain (master) and the FIFO itself (slave).
interface uart_tx_fifo_drain_if;

   logic                           fifo_empty;
   logic [uart_pkg::DATA_BITS-1:0] fifo_data;
   logic                           fifo_pop;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_pop
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_pop
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..DIV-1 and flags the last clock of each bit period.
module uart_baud_cnt #(
   parameter  int DIV = 10,
   localparam int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         tick
);

   localparam logic [W-1:0] CNT_LAST = W'(DIV - 1);

   logic [W-1:0] cnt_reg;

   // Wrapping on the tick keeps every bit exactly DIV clocks, so no drift builds up over a frame.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_reg <= '0;
      end else if (tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign cnt  = cnt_reg;
   assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from the TX FIFO while it is non-empty and sends them 8N1/8N2.
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD      = 115_200,
   parameter int STOP_BITS = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   uart_tx_fifo_drain_if.master      fifo,
   output logic                      tx,
   output logic                      busy,
   output logic                      tx_done
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_LOAD  = ST_LOAD;
   localparam logic [2:0] S_START = ST_START;
   localparam logic [2:0] S_DATA  = ST_DATA;
   localparam logic [2:0] S_STOP  = ST_STOP;

   localparam logic [CW-1:0] CNT_PRE   = CW'(DIV - 2);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   logic [2:0]           state_reg,    state_next;
   logic [DATA_BITS-1:0] shift_reg,    shift_next;
   logic [BW-1:0]        bit_idx_reg,  bit_idx_next;
   logic                 stop_cnt_reg, stop_cnt_next;
   logic                 tx_reg,       tx_next;
   logic                 busy_reg,     busy_next;
   logic                 pop_reg,      pop_next;
   logic                 done_reg,     done_next;

   logic [CW-1:0] baud_cnt;
   logic          baud_tick;
   logic          baud_clr;

   assign baud_clr = (state_reg == S_IDLE) || (state_reg == S_LOAD);

   uart_baud_cnt #(.DIV(DIV)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (baud_clr),
      .cnt  (baud_cnt),
      .tick (baud_tick)
   );

   // Outputs are registered from the next-state values so they line up with state_reg.
   // The pop is raised while entering IDLE so a queued byte leaves only two idle-high clocks.
   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      bit_idx_next  = bit_idx_reg;
      stop_cnt_next = stop_cnt_reg;
      pop_next      = 1'b0;
      done_next     = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (pop_reg) begin
               state_next = S_LOAD;
            end else if (!fifo.fifo_empty) begin
               pop_next = 1'b1;
            end
         end
         S_LOAD: begin
            shift_next    = fifo.fifo_data;
            bit_idx_next  = '0;
            stop_cnt_next = 1'b0;
            state_next    = S_START;
         end
         S_START: begin
            if (baud_tick) begin
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               shift_next = shift_reg >> 1;
               if (bit_idx_reg == BIT_LAST) begin
                  state_next = S_STOP;
               end else begin
                  bit_idx_next = bit_idx_reg + 1'b1;
               end
            end
         end
         S_STOP: begin
            // One clock early so the registered pulse lands on the final stop clock (needs DIV >= 2).
            if (stop_cnt_reg == STOP_LAST && baud_cnt == CNT_PRE) begin
               done_next = 1'b1;
            end
            if (baud_tick) begin
               if (stop_cnt_reg == STOP_LAST) begin
                  state_next = S_IDLE;
                  pop_next   = !fifo.fifo_empty;
               end else begin
                  stop_cnt_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      case (state_next)
         S_START: tx_next = 1'b0;
         S_DATA:  tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase

      busy_next = (state_next != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         shift_reg    <= '0;
         bit_idx_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         pop_reg      <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         bit_idx_reg  <= bit_idx_next;
         stop_cnt_reg <= stop_cnt_next;
         tx_reg       <= tx_next;
         busy_reg     <= busy_next;
         pop_reg      <= pop_next;
         done_reg     <= done_next;
      end
   end

   assign fifo.fifo_pop = pop_reg;
   assign tx            = tx_reg;
   assign busy          = busy_reg;
   assign tx_done       = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: one instance per stop-bit setting, FIFO models and a byte scoreboard.
module tb_uart_tx_fifo_drain;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int DIV      = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0] tx_w, busy_w, done_w, pop_w;

   logic [7:0] fmem [2][16];
   int         fwr  [2] = '{0, 0};
   logic [7:0] exp_q [$];
   int         gaps  [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic push(input int k, input logic [7:0] b);
      fmem[k][fwr[k]] = b;
      fwr[k]          = fwr[k] + 1;
      exp_q.push_back(b);
   endtask

   // Returns on the negedge where the pop (is_done=0) or tx_done (is_done=1) of instance k is seen.
   task automatic wait_evt(input int k, input bit is_done, input int limit, input string tag);
      logic hit = 1'b0;
      for (int n = 0; n < limit && !hit; n++) begin
         @(negedge clk);
         hit = is_done ? done_w[k] : pop_w[k];
      end
      check(tag, hit, 1);
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g
      localparam int SB = gi + 1;
      localparam int L  = DIV * (1 + 8 + SB);

      uart_tx_fifo_drain_if fif ();

      int         frd       = 0;
      logic [7:0] fdata     = 8'h00;
      int         pops      = 0;
      int         dones     = 0;
      logic       in_fr     = 1'b0;
      logic       have_done = 1'b0;
      logic       prev_busy = 1'b0;
      int         pos       = 0;
      int         pop_cyc   = 0;
      int         done_cyc  = 0;
      int         bad_lvl, bad_busy, bad_done;
      logic [7:0] exp_b, rx_b;

      assign fif.fifo_empty = (fwr[gi] == frd);
      assign fif.fifo_data  = fdata;
      assign pop_w[gi]      = fif.fifo_pop;

      uart_tx_fifo_drain #(
         .CLK_FREQ  (CLK_FREQ),
         .BAUD      (BAUD),
         .STOP_BITS (SB)
      ) dut (
         .clk     (clk),
         .rst     (rst),
         .fifo    (fif.master),
         .tx      (tx_w[gi]),
         .busy    (busy_w[gi]),
         .tx_done (done_w[gi])
      );

      // FIFO data is registered: it appears the cycle after the pop.
      always @(posedge clk) begin
         if (fif.fifo_pop) begin
            fdata <= fmem[gi][frd];
            frd   <= frd + 1;
         end
      end

      always @(negedge clk) begin : mon
         logic lvl;
         int   bn;
         if (rst) begin
            in_fr     = 1'b0;
            have_done = 1'b0;
         end else begin
            if (pop_w[gi]) begin
               pops++;
               check("pop_when_empty", fif.fifo_empty, 0);
               check("busy_at_pop", busy_w[gi], 0);
               pop_cyc = cyc;
            end
            if (done_w[gi]) dones++;
            if (!in_fr && tx_w[gi] === 1'b0) begin
               in_fr    = 1'b1;
               pos      = 0;
               bad_lvl  = 0;
               bad_busy = 0;
               bad_done = 0;
               rx_b     = 8'h00;
               check("busy_in_load", prev_busy, 1);
               check("pop_to_start", cyc - pop_cyc, 2);
               if (have_done) gaps.push_back(cyc - done_cyc - 1);
               check("sb_has_entry", exp_q.size() > 0, 1);
               exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            end else if (!in_fr) begin
               check("done_outside_frame", done_w[gi], 0);
            end
            if (in_fr) begin
               bn  = pos / DIV;
               lvl = (bn == 0) ? 1'b0 : (bn <= 8) ? exp_b[bn-1] : 1'b1;
               if (bn >= 1 && bn <= 8 && (pos % DIV) == DIV / 2) rx_b[bn-1] = tx_w[gi];
               if (tx_w[gi] !== lvl) bad_lvl++;
               if (busy_w[gi] !== 1'b1) bad_busy++;
               if (done_w[gi] !== (pos == L - 1)) bad_done++;
               pos++;
               if (pos == L) begin
                  check("frame_level", bad_lvl, 0);
                  check("frame_busy", bad_busy, 0);
                  check("frame_done", bad_done, 0);
                  check("frame_byte", rx_b, exp_b);
                  $display("frame sb=%0d byte=%02h expected=%02h", SB, rx_b, exp_b);
                  in_fr     = 1'b0;
                  have_done = 1'b1;
                  done_cyc  = cyc;
               end
            end
         end
         prev_busy = busy_w[gi];
      end
   end

   initial begin
      int p0, d0, c0, bad, early;
      logic hit;

      repeat (3) @(negedge clk);
      check("rst_tx", tx_w, 2'b11);
      check("rst_busy", busy_w, 2'b00);
      check("rst_pop", pop_w, 2'b00);
      check("rst_done", done_w, 2'b00);
      rst = 1'b0;

      // Single byte 0xA5
      p0 = g[0].pops;
      d0 = g[0].dones;
      push(0, 8'hA5);
      wait_evt(0, 1, 300, "t1_done");
      @(negedge clk);
      check("t1_busy_after", busy_w[0], 0);
      check("t1_tx_after", tx_w[0], 1);
      check("t1_pops", g[0].pops - p0, 1);
      check("t1_dones", g[0].dones - d0, 1);

      // Three queued bytes back to back
      gaps.delete();
      p0 = g[0].pops;
      push(0, 8'h00);
      push(0, 8'hFF);
      push(0, 8'h55);
      for (int i = 0; i < 3; i++) wait_evt(0, 1, 300, "t2_done");
      @(negedge clk);
      check("t2_pops", g[0].pops - p0, 3);
      check("t2_gap_count", gaps.size(), 3);
      check("t2_gap1", (gaps.size() > 1) ? gaps[1] : -1, 2);
      check("t2_gap2", (gaps.size() > 2) ? gaps[2] : -1, 2);

      // Empty FIFO stays quiet
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (pop_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) bad++;
      end
      check("t3_idle_quiet", bad, 0);

      // Reset during data bit 3 of 0x3C with 0x81 still queued
      push(0, 8'h3C);
      push(0, 8'h81);
      wait_evt(0, 0, 20, "t4_pop");
      repeat (45) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t4_tx_rst", tx_w[0], 1);
      check("t4_busy_rst", busy_w[0], 0);
      check("t4_done_rst", done_w[0], 0);
      repeat (3) begin
         @(negedge clk);
         check("t4_pop_in_rst", pop_w[0], 0);
      end
      p0  = g[0].pops;
      rst = 1'b0;
      wait_evt(0, 1, 300, "t4_done");
      check("t4_pops", g[0].pops - p0, 1);
      check("t4_sb_empty", exp_q.size(), 0);

      // FIFO becomes non-empty mid-frame
      push(0, 8'h11);
      wait_evt(0, 0, 20, "t6_pop1");
      repeat (30) @(negedge clk);
      push(0, 8'h22);
      early = 0;
      hit   = 1'b0;
      for (int n = 0; n < 300 && !hit; n++) begin
         @(negedge clk);
         if (pop_w[0]) early++;
         hit = done_w[0];
      end
      check("t6_done_seen", hit, 1);
      check("t6_no_early_pop", early, 0);
      @(negedge clk);
      check("t6_pop_after_done", pop_w[0], 1);
      wait_evt(0, 1, 300, "t6_done2");

      // Two stop bits, 0x7E
      push(1, 8'h7E);
      wait_evt(1, 0, 20, "t5_pop");
      c0 = cyc;
      wait_evt(1, 1, 300, "t5_done");
      check("t5_pop_to_done", cyc - c0, 111);

      repeat (5) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      check("dut1_idle", g[1].pops, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
